// File: rtl/jtag_rx_intfc_pkg.sv
// Shared NI register map and receive-FSM state encoding for the JTAG receive interface.
// The register offsets are common with the transmit-side injector.
package jtag_rx_intfc_pkg;

   localparam logic [31:0] NI_STATUS        = 32'd0;
   localparam logic [31:0] NI_RD_MEM_PCKSIZ = 32'd1;
   localparam logic [31:0] NI_WR_MEM_PCKSIZ = 32'd2;
   localparam logic [31:0] NI_PCK_SIZE      = 32'd3;
   localparam logic [31:0] NI_RD_MEM        = 32'd4;
   localparam logic [31:0] NI_WR_MEM        = 32'd5;
   localparam int unsigned NI_BUSY_LOC      = 0;

   typedef enum logic [4:0] {
      ST_IDLE    = 5'b00001,
      ST_WR_SIZE = 5'b00010,
      ST_WR_PTR  = 5'b00100,
      ST_WAIT    = 5'b01000,
      ST_POLL    = 5'b10000
   } rx_state_e;

endpackage

// File: rtl/jtag_rx_intfc_buf.sv
// Receive buffer: byte-enabled write port shared by the slave, one registered read port
// for the host and one for the slave. Reads return pre-write data on same-address collisions.
module jtag_rx_buf #(
   parameter int Aw   = 8,
   parameter int Dw   = 32,
   parameter int SELw = 4
) (
   input  logic            clk,
   input  logic            wr_en_i,
   input  logic [Aw-1:0]   wr_addr_i,
   input  logic [SELw-1:0] wr_sel_i,
   input  logic [Dw-1:0]   wr_dat_i,
   input  logic [Aw-1:0]   rd_addr_a_i,
   output logic [Dw-1:0]   rd_dat_a_o,
   input  logic [Aw-1:0]   rd_addr_b_i,
   output logic [Dw-1:0]   rd_dat_b_o
);

   logic [Dw-1:0] mem_q [2**Aw];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         for (int b = 0; b < SELw; b++) begin
            if (wr_sel_i[b]) mem_q[wr_addr_i][b*8 +: 8] <= wr_dat_i[b*8 +: 8];
         end
      end
      rd_dat_a_o <= mem_q[rd_addr_a_i];
      rd_dat_b_o <= mem_q[rd_addr_b_i];
   end

endmodule

// File: rtl/jtag_rx_intfc.sv
// JTAG receive interface: on a host start falling edge, programs the NI to DMA one packet
// into the local buffer, then polls NI status until the receive completes.
module jtag_rx_intfc
   import jtag_rx_intfc_pkg::*;
#(
   parameter logic [31:0] NI_BASE_ADDR   = 32'h0,
   parameter logic [31:0] JTAG_BASE_ADDR = 32'h0,
   parameter int          RD_RAMw        = 8,
   parameter int          Dw             = 32,
   parameter int          S_Aw           = RD_RAMw,
   parameter int          M_Aw           = 32,
   parameter int          TAGw           = 3,
   parameter int          SELw           = 4,
   parameter int          WAIT_CYCLES    = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [RD_RAMw:0]   rd_buf_size,
   output logic               busy,
   output logic               overflow,
   output logic [RD_RAMw:0]   rx_words,
   input  logic [RD_RAMw-1:0] host_addr,
   output logic [Dw-1:0]      host_dat,
   input  logic [Dw-1:0]      s_dat_i,
   input  logic [SELw-1:0]    s_sel_i,
   input  logic [S_Aw-1:0]    s_addr_i,
   input  logic [TAGw-1:0]    s_tag_i,
   input  logic               s_stb_i,
   input  logic               s_cyc_i,
   input  logic               s_we_i,
   output logic [Dw-1:0]      s_dat_o,
   output logic               s_ack_o,
   output logic               s_err_o,
   output logic               s_rty_o,
   output logic [SELw-1:0]    m_sel_o,
   output logic [Dw-1:0]      m_dat_o,
   output logic [M_Aw-1:0]    m_addr_o,
   output logic [TAGw-1:0]    m_tag_o,
   output logic               m_stb_o,
   output logic               m_cyc_o,
   output logic               m_we_o,
   input  logic [Dw-1:0]      m_dat_i,
   input  logic               m_ack_i,
   input  logic               m_err_i,
   input  logic               m_rty_i
);

   localparam int CNTw = $clog2(WAIT_CYCLES + 1);

   rx_state_e        state_q, state_d;
   logic             start_q;
   logic [CNTw-1:0]  cnt_q;
   logic [RD_RAMw:0] size_q;
   logic [RD_RAMw:0] rx_words_q;
   logic             overflow_q;
   logic             s_ack_q;

   logic             trig;
   logic             s_req;
   logic             in_range;
   logic             buf_we;
   logic [RD_RAMw:0] s_addr_ext;
   logic [RD_RAMw:0] s_addr_p1;

   assign trig       = start_q & ~start;
   // Suppress a second ack while the master still holds the strobe from the acked request.
   assign s_req      = s_stb_i & s_cyc_i & ~s_ack_q;
   assign s_addr_ext = {1'b0, s_addr_i[RD_RAMw-1:0]};
   assign s_addr_p1  = s_addr_ext + (RD_RAMw+1)'(1);
   assign in_range   = s_addr_ext < size_q;
   assign buf_we     = s_req & s_we_i & in_range;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         start_q    <= 1'b0;
         cnt_q      <= '0;
         size_q     <= '0;
         rx_words_q <= '0;
         overflow_q <= 1'b0;
         s_ack_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         s_ack_q <= s_req;
         cnt_q   <= (state_q == ST_WAIT) ? cnt_q + CNTw'(1) : '0;
         if (trig && state_q == ST_IDLE) begin
            size_q     <= rd_buf_size;
            rx_words_q <= '0;
            overflow_q <= 1'b0;
         end else if (s_req && s_we_i) begin
            if (!in_range)                   overflow_q <= 1'b1;
            else if (s_addr_p1 > rx_words_q) rx_words_q <= s_addr_p1;
         end
      end
   end

   // Errors and retries leave the state untouched, so the same access is simply re-issued.
   always_comb begin
      state_d  = state_q;
      m_stb_o  = 1'b0;
      m_cyc_o  = 1'b0;
      m_we_o   = 1'b0;
      m_addr_o = '0;
      m_dat_o  = '0;
      unique case (state_q)
         ST_IDLE: if (trig) state_d = ST_WR_SIZE;
         ST_WR_SIZE: begin
            m_stb_o  = 1'b1;
            m_cyc_o  = 1'b1;
            m_we_o   = 1'b1;
            m_addr_o = M_Aw'(NI_BASE_ADDR + NI_PCK_SIZE);
            m_dat_o  = Dw'(size_q);
            if (m_ack_i) state_d = ST_WR_PTR;
         end
         ST_WR_PTR: begin
            m_stb_o  = 1'b1;
            m_cyc_o  = 1'b1;
            m_we_o   = 1'b1;
            m_addr_o = M_Aw'(NI_BASE_ADDR + NI_RD_MEM);
            m_dat_o  = Dw'(JTAG_BASE_ADDR << 2);
            if (m_ack_i) state_d = ST_WAIT;
         end
         ST_WAIT: if (cnt_q == CNTw'(WAIT_CYCLES - 1)) state_d = ST_POLL;
         ST_POLL: begin
            m_stb_o  = 1'b1;
            m_cyc_o  = 1'b1;
            m_addr_o = M_Aw'(NI_BASE_ADDR + NI_STATUS);
            if (m_ack_i) state_d = m_dat_i[NI_BUSY_LOC] ? ST_WAIT : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy     = (state_q != ST_IDLE);
   assign overflow = overflow_q;
   assign rx_words = rx_words_q;
   assign s_ack_o  = s_ack_q;
   assign s_err_o  = 1'b0;
   assign s_rty_o  = 1'b0;
   assign m_sel_o  = '1;
   assign m_tag_o  = '0;

   logic unused_ok;
   assign unused_ok = ^{s_tag_i, m_err_i, m_rty_i, m_dat_i};

   jtag_rx_buf #(
      .Aw   (RD_RAMw),
      .Dw   (Dw),
      .SELw (SELw)
   ) u_buf (
      .clk         (clk),
      .wr_en_i     (buf_we),
      .wr_addr_i   (s_addr_i[RD_RAMw-1:0]),
      .wr_sel_i    (s_sel_i),
      .wr_dat_i    (s_dat_i),
      .rd_addr_a_i (host_addr),
      .rd_dat_a_o  (host_dat),
      .rd_addr_b_i (s_addr_i[RD_RAMw-1:0]),
      .rd_dat_b_o  (s_dat_o)
   );

endmodule

// File: tb/tb_jtag_rx_intfc.sv
// Bench for jtag_rx_intfc: an NI model serves master accesses against a queue of expected
// accesses pushed at each start; slave and host ports are exercised directly.
module tb_jtag_rx_intfc;

   localparam logic [31:0] NI_BASE = 32'h10;
   localparam logic [31:0] JBASE   = 32'h40;
   localparam int RW = 4;
   localparam int WC = 8;

   logic          clk, reset, start;
   logic [RW:0]   rd_buf_size;
   logic          busy, overflow;
   logic [RW:0]   rx_words;
   logic [RW-1:0] host_addr;
   logic [31:0]   host_dat;
   logic [31:0]   s_dat_i, s_dat_o;
   logic [3:0]    s_sel_i;
   logic [RW-1:0] s_addr_i;
   logic [2:0]    s_tag_i;
   logic          s_stb_i, s_cyc_i, s_we_i, s_ack_o, s_err_o, s_rty_o;
   logic [3:0]    m_sel_o;
   logic [31:0]   m_dat_o, m_addr_o, m_dat_i;
   logic [2:0]    m_tag_o;
   logic          m_stb_o, m_cyc_o, m_we_o, m_ack_i, m_err_i, m_rty_i;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] dat;
   } acc_t;

   acc_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   logic [31:0] pat [4] = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};

   jtag_rx_intfc #(
      .NI_BASE_ADDR (NI_BASE), .JTAG_BASE_ADDR (JBASE), .RD_RAMw (RW), .Dw (32),
      .S_Aw (RW), .M_Aw (32), .TAGw (3), .SELw (4), .WAIT_CYCLES (WC)
   ) dut (
      .clk (clk), .reset (reset), .start (start), .rd_buf_size (rd_buf_size),
      .busy (busy), .overflow (overflow), .rx_words (rx_words),
      .host_addr (host_addr), .host_dat (host_dat),
      .s_dat_i (s_dat_i), .s_sel_i (s_sel_i), .s_addr_i (s_addr_i), .s_tag_i (s_tag_i),
      .s_stb_i (s_stb_i), .s_cyc_i (s_cyc_i), .s_we_i (s_we_i),
      .s_dat_o (s_dat_o), .s_ack_o (s_ack_o), .s_err_o (s_err_o), .s_rty_o (s_rty_o),
      .m_sel_o (m_sel_o), .m_dat_o (m_dat_o), .m_addr_o (m_addr_o), .m_tag_o (m_tag_o),
      .m_stb_o (m_stb_o), .m_cyc_o (m_cyc_o), .m_we_o (m_we_o),
      .m_dat_i (m_dat_i), .m_ack_i (m_ack_i), .m_err_i (m_err_i), .m_rty_i (m_rty_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // NI model: waits for a master access, checks it against the scoreboard, acks it.
   task automatic ni_serve(input logic [31:0] rdata, output int waited);
      acc_t e;
      waited = 0;
      while (!(m_cyc_o && m_stb_o) && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (!(m_cyc_o && m_stb_o)) begin
         bad++;
         $display("FAIL ni_timeout: m_cyc=%0b m_stb=%0b, required 1/1", m_cyc_o, m_stb_o);
         return;
      end
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL ni_unexpected: we=%0b addr=%h, required no access", m_we_o, m_addr_o);
      end else begin
         e = exp_q.pop_front();
         if (m_we_o !== e.we || m_addr_o !== e.addr || (e.we && m_dat_o !== e.dat) ||
             m_sel_o !== 4'hF || m_tag_o !== 3'd0) begin
            bad++;
            $display("FAIL ni_access: got we=%0b addr=%h dat=%h sel=%h tag=%0d, required we=%0b addr=%h dat=%h sel=f tag=0",
                     m_we_o, m_addr_o, m_dat_o, m_sel_o, m_tag_o, e.we, e.addr, e.dat);
         end
      end
      m_ack_i = 1'b1;
      m_dat_i = rdata;
      @(negedge clk);
      m_ack_i = 1'b0;
      m_dat_i = '0;
   endtask

   task automatic slv(input logic we, input logic [RW-1:0] a, input logic [31:0] d, input logic [3:0] sel,
                      output logic ack1, output logic ack2, output logic [31:0] rd);
      s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we; s_addr_i = a; s_dat_i = d; s_sel_i = sel;
      @(negedge clk);
      ack1 = s_ack_o;
      rd   = s_dat_o;
      @(negedge clk);
      ack2 = s_ack_o;
      s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
   endtask

   task automatic host_rd(input logic [RW-1:0] a, output logic [31:0] d);
      host_addr = a;
      @(negedge clk);
      d = host_dat;
   endtask

   task automatic do_trigger(input logic [RW:0] size);
      rd_buf_size = size;
      exp_q.push_back('{we: 1'b1, addr: NI_BASE + 32'd3, dat: 32'(size)});
      exp_q.push_back('{we: 1'b1, addr: NI_BASE + 32'd4, dat: JBASE << 2});
      start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic push_poll();
      exp_q.push_back('{we: 1'b0, addr: NI_BASE, dat: 32'd0});
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; rd_buf_size = '0; host_addr = '0;
      s_dat_i = '0; s_sel_i = '0; s_addr_i = '0; s_tag_i = '0;
      s_stb_i = 1'b0; s_cyc_i = 1'b0; s_we_i = 1'b0;
      m_dat_i = '0; m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b required 0", overflow); end
      total++; if (rx_words !== '0) begin bad++; $display("FAIL reset_rx_words: got %0d required 0", rx_words); end
      total++; if (s_ack_o !== 1'b0) begin bad++; $display("FAIL reset_s_ack: got %b required 0", s_ack_o); end
      total++;
      if ({m_cyc_o, m_stb_o, m_we_o} !== 3'b000) begin
         bad++; $display("FAIL reset_master: cyc/stb/we=%b required 000", {m_cyc_o, m_stb_o, m_we_o});
      end
      total++; if (m_sel_o !== 4'hF) begin bad++; $display("FAIL reset_sel: got %h required f", m_sel_o); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_trigger();
      int w;
      do_trigger(5'd4);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL trig_pre_busy: got %b required 0", busy); end
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || m_cyc_o !== 1'b1) begin
         bad++; $display("FAIL trig_busy: busy=%b cyc=%b required 1/1", busy, m_cyc_o);
      end
      ni_serve(32'd0, w);
      ni_serve(32'd0, w);
   endtask

   task automatic test_receive();
      logic a1, a2;
      logic [31:0] rd;
      int w;
      for (int i = 0; i < 4; i++) begin
         slv(1'b1, RW'(i), pat[i], 4'hF, a1, a2, rd);
         total++;
         if (a1 !== 1'b1 || a2 !== 1'b0) begin
            bad++; $display("FAIL rx_write_ack[%0d]: ack=%b,%b required 1,0", i, a1, a2);
         end
      end
      push_poll(); push_poll(); push_poll();
      ni_serve(32'd1, w);
      ni_serve(32'd1, w);
      total++; if (w < WC) begin bad++; $display("FAIL poll_gap1: got %0d cycles required >=%0d", w, WC); end
      ni_serve(32'd0, w);
      total++; if (w < WC) begin bad++; $display("FAIL poll_gap2: got %0d cycles required >=%0d", w, WC); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rx_done_busy: got %b required 0", busy); end
      total++; if (rx_words !== 5'd4) begin bad++; $display("FAIL rx_words: got %0d required 4", rx_words); end
      host_rd(2, rd);
      total++; if (rd !== pat[2]) begin bad++; $display("FAIL host_rd2: got %h required %h", rd, pat[2]); end
      slv(1'b0, 1, 32'd0, 4'hF, a1, a2, rd);
      total++;
      if (a1 !== 1'b1 || rd !== pat[1]) begin
         bad++; $display("FAIL slave_rd1: ack=%b dat=%h required 1 %h", a1, rd, pat[1]);
      end
   endtask

   task automatic test_byte_sel();
      logic a1, a2;
      logic [31:0] rd;
      slv(1'b1, 0, 32'h0, 4'hF, a1, a2, rd);
      slv(1'b1, 0, 32'hFFFF_FFFF, 4'b0010, a1, a2, rd);
      host_rd(0, rd);
      total++; if (rd !== 32'h0000_FF00) begin bad++; $display("FAIL byte_sel_host: got %h required 0000ff00", rd); end
      slv(1'b0, 0, 32'd0, 4'hF, a1, a2, rd);
      total++; if (rd !== 32'h0000_FF00) begin bad++; $display("FAIL byte_sel_slave: got %h required 0000ff00", rd); end
   endtask

   task automatic test_back_to_back();
      logic a1, a2;
      logic [31:0] rd;
      int w, seen;
      do_trigger(5'd8);
      ni_serve(32'd0, w);
      ni_serve(32'd0, w);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      slv(1'b1, 5, 32'h55AA_55AA, 4'hF, a1, a2, rd);
      total++; if (rx_words !== 5'd6) begin bad++; $display("FAIL b2b_rx_words: got %0d required 6", rx_words); end
      push_poll();
      ni_serve(32'd0, w);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (m_cyc_o) seen++;
      end
      total++;
      if (seen != 0 || exp_q.size() != 0) begin
         bad++; $display("FAIL b2b_extra: cyc cycles=%0d pending=%0d required 0/0", seen, exp_q.size());
      end
   endtask

   task automatic test_reset_poll();
      int w, n;
      do_trigger(5'd4);
      ni_serve(32'd0, w);
      ni_serve(32'd0, w);
      n = 0;
      while (!(m_stb_o && !m_we_o) && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!(m_stb_o && !m_we_o && m_addr_o === NI_BASE)) begin
         bad++; $display("FAIL rst_poll_seen: stb=%b we=%b addr=%h required 1 0 %h", m_stb_o, m_we_o, m_addr_o, NI_BASE);
      end
      reset = 1'b1;
      #1;
      total++;
      if (m_cyc_o !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL rst_poll_drop: cyc=%b busy=%b required 0/0", m_cyc_o, busy);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_trigger(5'd4);
      ni_serve(32'd0, w);
      ni_serve(32'd0, w);
      push_poll();
      ni_serve(32'd0, w);
      total++;
      if (busy !== 1'b0 || rx_words !== '0) begin
         bad++; $display("FAIL rst_rerun: busy=%b rx_words=%0d required 0/0", busy, rx_words);
      end
   endtask

   task automatic test_overflow();
      logic a1, a2;
      logic [31:0] rd;
      logic [RW:0] rxw;
      rxw = rx_words;
      slv(1'b1, 5, 32'hDEAD_BEEF, 4'hF, a1, a2, rd);
      total++; if (a1 !== 1'b1) begin bad++; $display("FAIL ovf_ack: got %b required 1", a1); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b required 1", overflow); end
      total++; if (rx_words !== rxw) begin bad++; $display("FAIL ovf_rx_words: got %0d required %0d", rx_words, rxw); end
      host_rd(5, rd);
      total++; if (rd !== 32'h55AA_55AA) begin bad++; $display("FAIL ovf_buf: got %h required 55aa55aa", rd); end
   endtask

   task automatic test_clear();
      int w;
      do_trigger(5'd4);
      @(negedge clk);
      total++;
      if (overflow !== 1'b0 || rx_words !== '0) begin
         bad++; $display("FAIL clear_on_trig: overflow=%b rx_words=%0d required 0/0", overflow, rx_words);
      end
      ni_serve(32'd0, w);
      ni_serve(32'd0, w);
      push_poll();
      ni_serve(32'd0, w);
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_trigger();
      test_receive();
      test_byte_sel();
      test_back_to_back();
      test_reset_poll();
      test_overflow();
      test_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
